// File: rtl/aes_req_arbiter_pkg.sv
// aes_req_arbiter_pkg: shared FSM states, op codes and key length codes for the AES request arbiter
package aes_req_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, KEY_LOAD, KEY_WAIT, ISSUE, WAIT_CORE, RESP} state_t;
  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;
  localparam logic [1:0] KEY_128 = 2'b01;
  localparam logic [1:0] KEY_192 = 2'b10;
  localparam logic [1:0] KEY_256 = 2'b11;
  function automatic logic key_len_ok(input logic [1:0] len);
    return len == KEY_128 || len == KEY_192 || len == KEY_256;
  endfunction
  function automatic logic [1:0] onehot2(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/aes_rr_arb2.sv
// aes_rr_arb2: 2-way round-robin grant with last-grant register
// ports: clk, reset (sync, active-high); req = request vector; accept = grant taken this cycle;
//        grant = winner index; gnt = winner one-hot
module aes_rr_arb2
  import aes_req_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant,
  output logic [1:0] gnt
);
  logic last;
  // on a tie (or no request) the requester not granted last wins
  always_comb begin
    grant = (req == 2'b11 || req == 2'b00) ? ~last : req[1];
    gnt = onehot2(grant);
  end
  always_ff @(posedge clk)
    if (reset) last <= 1'b1;
    else if (accept) last <= grant;
endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: shares one AES core between two requesters and a key loader
// ports: clk, reset (sync, active-high)
//        req_valid/req_ready/req_op/req_data: per-requester op handshake (data [128i+127:128i])
//        resp_valid/resp_ready/resp_data/resp_err: per-requester result handshake
//        key_req/key_len_in/key_in/key_ack: key load request, key_ack pulses when done
//        aes_*: AES core interface; busy: FSM not idle
module aes_req_arbiter
  import aes_req_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_op,
  input  logic [255:0] req_data,
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic [127:0] resp_data,
  output logic         resp_err,
  input  logic         key_req,
  input  logic [1:0]   key_len_in,
  input  logic [255:0] key_in,
  output logic         key_ack,
  output logic         aes_pt_valid,
  output logic [127:0] aes_pt_encr,
  input  logic         aes_ct_rdy,
  input  logic [127:0] aes_ct_encr,
  output logic         aes_ct_valid,
  output logic [127:0] aes_ct_decr,
  input  logic         aes_pt_rdy,
  input  logic [127:0] aes_pt_decr,
  output logic [1:0]   aes_key_len,
  output logic [255:0] aes_short_key,
  input  logic         aes_key_mem_status,
  input  logic         aes_error,
  output logic         busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, next;
  logic key_loaded, can_accept, accept, win, gidx, op, first, core_rdy, done_ok, done_err;
  logic [1:0] win_oh;
  logic [CW-1:0] cnt;
  logic [127:0] core_data, sel_data;
  aes_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .accept (accept),
    .grant  (win),
    .gnt    (win_oh)
  );
  always_comb begin
    can_accept = state == IDLE && key_loaded && !key_req;
    req_ready = can_accept ? win_oh : 2'b00;
    accept = |(req_valid & req_ready);
    sel_data = win ? req_data[255:128] : req_data[127:0];
    core_rdy = op == OP_ENC ? aes_ct_rdy : aes_pt_rdy;
    core_data = op == OP_ENC ? aes_ct_encr : aes_pt_decr;
    // the core's ready from the previous op may still be up in the first wait cycle
    first = cnt == '0;
    done_ok = state == WAIT_CORE && !aes_error && !first && core_rdy;
    done_err = state == WAIT_CORE && !done_ok && (aes_error || cnt == CW'(TIMEOUT - 1));
    key_ack = (state == KEY_WAIT && aes_key_mem_status) ||
              (state == IDLE && key_req && !key_len_ok(key_len_in));
    busy = state != IDLE;
    aes_pt_valid = state == ISSUE && op == OP_ENC;
    aes_ct_valid = state == ISSUE && op == OP_DEC;
    resp_valid = state == RESP ? onehot2(gidx) : 2'b00;
    next = state;
    case (state)
      IDLE:      next = key_req ? (key_len_ok(key_len_in) ? KEY_LOAD : IDLE) : (accept ? ISSUE : IDLE);
      KEY_LOAD:  next = KEY_WAIT;
      KEY_WAIT:  next = aes_key_mem_status ? IDLE : KEY_WAIT;
      ISSUE:     next = WAIT_CORE;
      WAIT_CORE: next = (done_ok || done_err) ? RESP : WAIT_CORE;
      RESP:      next = resp_ready[gidx] ? IDLE : RESP;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      key_loaded <= 1'b0;
      gidx <= 1'b0;
      op <= OP_ENC;
      cnt <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
      aes_key_len <= 2'b00;
      aes_short_key <= '0;
      aes_pt_encr <= '0;
      aes_ct_decr <= '0;
    end else begin
      state <= next;
      cnt <= state == WAIT_CORE ? cnt + 1'b1 : '0;
      key_loaded <= key_loaded | (state == KEY_WAIT && aes_key_mem_status);
      // registered on entry so the core sees the length for exactly the KEY_LOAD cycle
      aes_key_len <= (state == IDLE && next == KEY_LOAD) ? key_len_in : 2'b00;
      if (state == IDLE && next == KEY_LOAD) aes_short_key <= key_in;
      if (accept) begin
        gidx <= win;
        op <= req_op[win];
        if (req_op[win] == OP_ENC) aes_pt_encr <= sel_data;
        else aes_ct_decr <= sel_data;
      end
      if (done_ok || done_err) begin
        resp_data <= done_ok ? core_data : '0;
        resp_err <= done_err;
      end
    end
  end
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: directed self-checking bench for aes_req_arbiter
module tb_aes_req_arbiter;
  logic clk = 1'b0, reset;
  logic [1:0] req_valid, req_ready, req_op, resp_valid, resp_ready, key_len_in, aes_key_len;
  logic [255:0] req_data, key_in, aes_short_key;
  logic [127:0] resp_data, aes_pt_encr, aes_ct_encr, aes_ct_decr, aes_pt_decr;
  logic resp_err, key_req, key_ack, aes_pt_valid, aes_ct_rdy, aes_ct_valid, aes_pt_rdy;
  logic aes_key_mem_status, aes_error, busy;
  int checks = 0, failures = 0;
  localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY2 = 256'hfeedface_00000000_11111111_22222222_33333333_44444444_55555555_cafef00d;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D0 = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] D1 = 128'hdeadbeef000000001111111122222222;

  aes_req_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .key_req(key_req), .key_len_in(key_len_in), .key_in(key_in),
    .key_ack(key_ack), .aes_pt_valid(aes_pt_valid), .aes_pt_encr(aes_pt_encr),
    .aes_ct_rdy(aes_ct_rdy), .aes_ct_encr(aes_ct_encr), .aes_ct_valid(aes_ct_valid),
    .aes_ct_decr(aes_ct_decr), .aes_pt_rdy(aes_pt_rdy), .aes_pt_decr(aes_pt_decr),
    .aes_key_len(aes_key_len), .aes_short_key(aes_short_key),
    .aes_key_mem_status(aes_key_mem_status), .aes_error(aes_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input string tag, input logic [1:0] len, input logic [255:0] k, input int wait_n);
    key_req = 1'b1; key_len_in = len; key_in = k;
    #1 chk({tag, " ack idle"}, key_ack, 0);
    cyc();
    chk({tag, " key_len load"}, aes_key_len, len);
    chk({tag, " short_key load"}, aes_short_key, k);
    chk({tag, " busy load"}, busy, 1);
    cyc();
    chk({tag, " key_len wait"}, aes_key_len, 0);
    chk({tag, " short_key hold"}, aes_short_key, k);
    for (int i = 0; i < wait_n; i++) begin
      cyc();
      chk({tag, " ack early"}, key_ack, 0);
      chk({tag, " key_len late"}, aes_key_len, 0);
    end
    aes_key_mem_status = 1'b1;
    #1 chk({tag, " ack pulse"}, key_ack, 1);
    cyc();
    key_req = 1'b0; aes_key_mem_status = 1'b0;
    #1 chk({tag, " ack end"}, key_ack, 0);
    chk({tag, " busy end"}, busy, 0);
  endtask

  task automatic do_op(input string tag, input logic g, input logic o, input logic [127:0] din, input logic [127:0] cout);
    #1 chk({tag, " ready"}, req_ready, g ? 2'b10 : 2'b01);
    cyc();
    chk({tag, " pt_valid"}, aes_pt_valid, !o);
    chk({tag, " ct_valid"}, aes_ct_valid, o);
    chk({tag, " core data"}, o ? aes_ct_decr : aes_pt_encr, din);
    chk({tag, " busy"}, busy, 1);
    if (o) begin aes_pt_decr = cout; aes_pt_rdy = 1'b1; end
    else begin aes_ct_encr = cout; aes_ct_rdy = 1'b1; end
    cyc();
    chk({tag, " one pulse"}, {aes_pt_valid, aes_ct_valid}, 0);
    chk({tag, " resp early1"}, resp_valid, 0);
    cyc();
    chk({tag, " resp early2"}, resp_valid, 0);
    cyc();
    aes_ct_rdy = 1'b0; aes_pt_rdy = 1'b0;
    chk({tag, " resp_valid"}, resp_valid, g ? 2'b10 : 2'b01);
    chk({tag, " resp_data"}, resp_data, cout);
    chk({tag, " resp_err"}, resp_err, 0);
    resp_ready = g ? 2'b10 : 2'b01;
    cyc();
    resp_ready = 2'b00;
    #1 chk({tag, " resp drop"}, resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 0; req_op = 0; req_data = 0; resp_ready = 0; key_req = 0;
    key_len_in = 0; key_in = 0; aes_ct_rdy = 0; aes_ct_encr = 0; aes_pt_rdy = 0; aes_pt_decr = 0;
    aes_key_mem_status = 0; aes_error = 0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk("rst req_ready", req_ready, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_data", resp_data, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst key_ack", key_ack, 0);
    chk("rst valids", {aes_pt_valid, aes_ct_valid}, 0);
    chk("rst key_len", aes_key_len, 0);
    chk("rst short_key", aes_short_key, 0);
    chk("rst buses", {aes_pt_encr, aes_ct_decr}, 0);
    chk("rst busy", busy, 0);

    req_valid = 2'b01; req_data = {D1, PT};
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("nokey ready", req_ready, 0);
    end
    chk("nokey busy", busy, 0);
    req_valid = 2'b00;

    load_key("key1", 2'b01, KEY1, 8);

    req_op = 2'b10; req_data = {D1, D0}; req_valid = 2'b11;
    do_op("rr0", 1'b0, 1'b0, D0, 128'h1000);
    do_op("rr1", 1'b1, 1'b1, D1, 128'h2001);
    do_op("rr2", 1'b0, 1'b0, D0, 128'h3002);
    do_op("rr3", 1'b1, 1'b1, D1, 128'h4003);
    req_valid = 2'b00;

    req_op = 2'b00; req_data = {D1, PT}; req_valid = 2'b01;
    do_op("enc", 1'b0, 1'b0, PT, CT);
    req_valid = 2'b00;

    req_valid = 2'b01;
    #1 chk("err ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    cyc();
    aes_error = 1'b1;
    #1 chk("err resp early", resp_valid, 0);
    cyc();
    aes_error = 1'b0;
    chk("err resp_valid", resp_valid, 2'b01);
    chk("err resp_err", resp_err, 1);
    chk("err resp_data", resp_data, 0);
    resp_ready = 2'b01;
    cyc();
    resp_ready = 2'b00;

    req_op = 2'b10; req_valid = 2'b10;
    do_op("dec", 1'b1, 1'b1, D1, 128'h9999);
    req_valid = 2'b00;

    req_op = 2'b00; req_valid = 2'b10;
    #1 chk("to ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk("to resp early", resp_valid, 0);
      cyc();
    end
    chk("to resp_valid", resp_valid, 2'b10);
    chk("to resp_err", resp_err, 1);
    chk("to resp_data", resp_data, 0);
    resp_ready = 2'b10;
    cyc();
    resp_ready = 2'b00;

    req_valid = 2'b01;
    #1 chk("kw ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00; key_req = 1'b1; key_len_in = 2'b10; key_in = KEY2;
    cyc();
    chk("kw busy", busy, 1);
    chk("kw key_len", aes_key_len, 0);
    aes_ct_encr = 128'h5555aaaa; aes_ct_rdy = 1'b1;
    cyc();
    cyc();
    aes_ct_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("kw resp hold", resp_valid, 2'b01);
      chk("kw no load", aes_key_len, 0);
      cyc();
    end
    chk("kw resp_data", resp_data, 128'h5555aaaa);
    resp_ready = 2'b01;
    cyc();
    resp_ready = 2'b00;
    #1 chk("kw idle busy", busy, 0);
    chk("kw idle ready", req_ready, 0);
    chk("kw idle resp", resp_valid, 0);
    load_key("key2", 2'b10, KEY2, 2);

    req_valid = 2'b01; req_op = 2'b00;
    #1 chk("rst mid ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1 chk("rst mid busy", busy, 0);
    chk("rst mid ready0", req_ready, 0);
    chk("rst mid bus", aes_pt_encr, 0);
    aes_ct_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst mid no resp", resp_valid, 0);
    end
    aes_ct_rdy = 1'b0;

    key_req = 1'b1; key_len_in = 2'b00;
    #1 chk("len0 ack", key_ack, 1);
    cyc();
    chk("len0 idle", busy, 0);
    chk("len0 key_len", aes_key_len, 0);
    key_req = 1'b0;
    #1 chk("len0 ack end", key_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
